// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, FSM encoding and fetch address check for fetch_stage
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_NONE = 5'd0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // Misaligned or outside the instruction memory window.
    function automatic logic is_adel(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: pipeline control, instruction memory and F/D outputs
interface fetch_stage_if;
    logic        stall;
    logic [31:0] npc;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_Valid;
    logic [4:0]  D_ExcCode;

    modport master (
        input  stall, npc, i_inst_rdata,
        output i_inst_addr, F_PC, D_PC, D_Instr, D_Valid, D_ExcCode
    );

    modport slave (
        output stall, npc, i_inst_rdata,
        input  i_inst_addr, F_PC, D_PC, D_Instr, D_Valid, D_ExcCode
    );
endinterface

// File: rtl/fetch_stage_fd_reg.sv
// rtl/fetch_stage_fd_reg.sv - F/D pipeline register with load enable
import fetch_stage_pkg::*;

module fd_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [4:0]  exc_in,
    output logic [31:0] d_pc,
    output logic [31:0] d_instr,
    output logic        d_valid,
    output logic [4:0]  d_exc_code
);

    // Reset wins over a pending hold so no stalled instruction survives it.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc       <= 32'h0;
            d_instr    <= 32'h0;
            d_valid    <= 1'b0;
            d_exc_code <= EXC_NONE;
        end else if (en) begin
            d_pc       <= pc_in;
            d_instr    <= instr_in;
            d_valid    <= 1'b1;
            d_exc_code <= exc_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, BOOT/RUN FSM and F/D register; FETCH_EXC_EN enables AdEL detection
import fetch_stage_pkg::*;

module fetch_stage (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic         load;
    logic [31:0]  f_pc;
    logic [31:0]  fetch_instr;
    logic [4:0]   fetch_exc;
    logic [31:0]  d_pc;
    logic [31:0]  d_instr;
    logic         d_valid;
    logic [4:0]   d_exc_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            f_pc    <= PC_RESET;
        end else begin
            state_q <= state_d;
            if (load) begin
                f_pc <= bus.npc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            BOOT: begin
                if (!bus.stall) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                load = !bus.stall;
            end
            default: state_d = BOOT;
        endcase
    end

`ifdef FETCH_EXC_EN
    // A faulting fetch carries a nop so nothing downstream decodes garbage.
    always_comb begin
        if (is_adel(f_pc)) begin
            fetch_instr = 32'h0;
            fetch_exc   = EXC_ADEL;
        end else begin
            fetch_instr = bus.i_inst_rdata;
            fetch_exc   = EXC_NONE;
        end
    end
`else
    assign fetch_instr = bus.i_inst_rdata;
    assign fetch_exc   = EXC_NONE;
`endif

    fd_reg u_fd_reg (
        .clk        (clk),
        .reset      (reset),
        .en         (load),
        .pc_in      (f_pc),
        .instr_in   (fetch_instr),
        .exc_in     (fetch_exc),
        .d_pc       (d_pc),
        .d_instr    (d_instr),
        .d_valid    (d_valid),
        .d_exc_code (d_exc_code)
    );

    assign bus.i_inst_addr = f_pc;
    assign bus.F_PC        = f_pc;
    assign bus.D_PC        = d_pc;
    assign bus.D_Instr     = d_instr;
    assign bus.D_Valid     = d_valid;
    assign bus.D_ExcCode   = d_exc_code;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } fd_exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errs    = 0;

    fd_exp_t     sb[$];
    fd_exp_t     e;
    logic [31:0] m_fpc, m_dpc, m_instr;
    logic        m_valid, m_run;
    logic [4:0]  m_exc;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.i_inst_rdata = im_word(bus.i_inst_addr);

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("i_inst_addr", bus.i_inst_addr, m_fpc);
        chk("F_PC", bus.F_PC, m_fpc);
        chk("D_PC", bus.D_PC, m_dpc);
        chk("D_Instr", bus.D_Instr, m_instr);
        chk("D_Valid", 32'(bus.D_Valid), 32'(m_valid));
        chk("D_ExcCode", 32'(bus.D_ExcCode), 32'(m_exc));
        chk("state", 32'(dut.state_q), 32'(m_run));
    endtask

    task automatic step(input logic rst, input logic stl, input logic [31:0] next_pc);
        fd_exp_t x;
        @(negedge clk);
        reset     = rst;
        stall_drv(stl);
        bus.npc   = next_pc;
        if (!rst && !stl) begin
            x.pc = m_fpc;
`ifdef FETCH_EXC_EN
            x.instr = bad_addr(m_fpc) ? 32'h0 : im_word(m_fpc);
            x.exc   = bad_addr(m_fpc) ? 5'd4 : 5'd0;
`else
            x.instr = im_word(m_fpc);
            x.exc   = 5'd0;
`endif
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_fpc = 32'h0000_3000; m_dpc = 32'h0; m_instr = 32'h0;
            m_valid = 1'b0; m_exc = 5'd0; m_run = 1'b0;
        end else if (!stl) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                m_dpc = e.pc; m_instr = e.instr; m_exc = e.exc;
            end
            m_fpc = next_pc; m_valid = 1'b1; m_run = 1'b1;
        end
        check_all();
    endtask

    task automatic stall_drv(input logic s);
        bus.stall = s;
    endtask

    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.npc = 32'h0;
        m_fpc = 32'h0; m_dpc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_exc = 5'd0; m_run = 1'b0;

        // reset state, then sequential fetch
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0000_3004);
        step(1'b0, 1'b0, 32'h0000_3008);
        chk("seq_fpc", bus.F_PC, 32'h0000_3008);
        chk("seq_dpc", bus.D_PC, 32'h0000_3004);

        // stall for three cycles; npc ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom);
        chk("stall_dpc", bus.D_PC, 32'h0000_3004);
        step(1'b0, 1'b0, 32'h0000_300C);

        // jump keeps the delay slot
        step(1'b0, 1'b0, 32'h0000_3400);
        chk("jump_fpc", bus.F_PC, 32'h0000_3400);
        chk("jump_dpc", bus.D_PC, 32'h0000_300C);
        step(1'b0, 1'b0, 32'h0000_3404);

        // reset together with stall while D_Valid=1
        step(1'b1, 1'b1, 32'h0000_3500);
        chk("rst_stall_valid", 32'(bus.D_Valid), 32'd0);

        // BOOT holds under stall
        step(1'b0, 1'b1, 32'h0000_3100);
        step(1'b0, 1'b1, 32'h0000_3100);

        // address boundary cases
        step(1'b0, 1'b0, 32'h0000_3002);
        step(1'b0, 1'b0, 32'h0000_7000);
        step(1'b0, 1'b0, 32'h0000_6FFC);
        step(1'b0, 1'b0, 32'h0000_2FFC);
        step(1'b0, 1'b0, 32'h0000_3000);
        step(1'b0, 1'b0, 32'h0000_3010);

        // random mix of stalls and in-range targets
        for (int i = 0; i < 40; i++)
            step(1'b0, ($urandom_range(0, 3) == 0), 32'h0000_3000 + ($urandom_range(0, 32'h0FFF) << 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hazard-unit freeze of PC and F/D register.
REQ-005 npc  input  32  next-PC value computed by the next-PC stage.
REQ-006 i_inst_rdata  input  32  instruction word at i_inst_addr, combinational from external IM.
REQ-007 i_inst_addr  output  32  fetch address, equal to F_PC.
REQ-008 F_PC  output  32  current fetch PC, fed to the next-PC stage.
REQ-009 D_PC  output  32  PC of the instruction held in the F/D register.
REQ-010 D_Instr  output  32  instruction held in the F/D register.
REQ-011 D_Valid  output  1  F/D register holds a real fetched instruction.
REQ-012 D_ExcCode  output  5  fetch exception code for the D-stage instruction; 0 = none.

Function
REQ-013 Fetch SHALL keep a two-state FSM, BOOT and RUN; reset SHALL enter BOOT.
REQ-014 In BOOT with stall=0, the next edge SHALL load the F/D register and move the FSM to RUN.
REQ-015 In BOOT with stall=1, all registers SHALL hold and the FSM SHALL stay in BOOT.
REQ-016 RUN SHALL be left only by reset.
REQ-017 On each edge with stall=0 the block SHALL load F_PC<=npc, D_PC<=F_PC, D_Instr<=i_inst_rdata, D_Valid<=1, and D_ExcCode<=exception of F_PC.
REQ-018 On each edge with stall=1, F_PC, D_PC, D_Instr, D_Valid, D_ExcCode and the FSM SHALL all hold.
REQ-019 i_inst_addr SHALL equal F_PC combinationally, with zero latency.
REQ-020 F_PC to D output latency SHALL be one unstalled cycle.
REQ-021 The block SHALL apply no flush: branch delay slots always execute.
REQ-022 npc SHALL be taken verbatim, with no alignment masking.
REQ-023 If stall and reset are both asserted, reset SHALL take priority.

Reset
REQ-024 Reset SHALL set F_PC=32'h0000_3000, D_PC=0, D_Instr=0 (nop), D_Valid=0, D_ExcCode=0 and FSM=BOOT.
REQ-025 Reset asserted mid-stall SHALL discard the held instruction, leaving no residual D_Valid.

Configuration
REQ-026 The macro FETCH_EXC_EN SHALL enable fetch-exception detection.
REQ-027 When FETCH_EXC_EN is defined, a fetch with F_PC[1:0]!=0 or F_PC outside 0x3000..0x6FFC SHALL latch D_ExcCode=5'd4 (AdEL) and D_Instr=0.
REQ-028 When FETCH_EXC_EN is defined, an AdEL fetch SHALL still latch D_PC and set D_Valid=1.
REQ-029 When FETCH_EXC_EN is undefined, D_ExcCode SHALL be tied to 0, no range check SHALL be made, and D_Instr SHALL always equal the fetched word.

Structure
REQ-030 The shared constants header SHALL hold PC_RESET (32'h0000_3000), IM_BASE (0x3000), IM_TOP (0x6FFC), EXC_ADEL (5'd4), EXC_NONE (5'd0) and the FSM state encodings.
REQ-031 The F/D pipeline register (D_PC, D_Instr, D_Valid, D_ExcCode with enable) SHALL be one sub-module named fd_reg; the PC register and FSM SHALL stay in fetch_stage.

Verification
REQ-032 Reset for 1 cycle, then npc=F_PC+4 with stall=0 -> F_PC 0x3000, 0x3004, 0x3008; D_PC lags by one cycle; D_Valid=0 before the first edge, then 1.
REQ-033 Set stall=1 for 3 cycles at F_PC=0x3008 -> F_PC, D_PC=0x3004 and D_Instr all unchanged; resume -> F_PC=npc on the next edge.
REQ-034 Drive npc=0x3400 (jump) -> next F_PC=0x3400; D_PC=previous F_PC (delay slot kept, not flushed).
REQ-035 Assert reset together with stall while D_Valid=1 -> after the edge F_PC=0x3000, D_Valid=0, FSM=BOOT.
REQ-036 With FETCH_EXC_EN defined, npc=0x3002 -> after the next unstalled edge D_ExcCode=4, D_Instr=0, D_PC=0x3002; repeat with npc=0x7000 -> same result.
REQ-037 With FETCH_EXC_EN undefined, the same npc values -> D_ExcCode=0 and D_Instr equal to the IM data.
